vector_packer: RTL and testbench

- Producer side of the 256-bit lane bus that feeds the lane-sum reduction unit.
- Collects 16-bit scalar lanes one beat at a time over a valid/ready input, packs them into a 256-bit vector, and presents the vector on a valid/ready output.
- Supports two alternative ways to close a vector:
  - partial flush (zero-padded), so the reduction of the padded vector equals the sum of the written lanes only;
  - broadcast (replicate one scalar into every remaining lane).
- Lives in the datapath between the scalar register/forwarding path and the vector reduction and store logic.

---
 rtl/vector_packer_if.sv | 26 ++
 rtl/vector_packer.sv | 93 +++++++++
 tb/tb_vector_packer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/vector_packer_if.sv
// Handshake bundle between the scalar producer, the vector packer and the lane-sum consumer.
// The slave view belongs to the packer; the master view drives beats in and takes vectors out.
interface vector_packer_if #(
  parameter int LANE_W = 16,
  parameter int LANES  = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic [LANE_W-1:0]            in_data;
  logic                         in_last;
  logic                         in_bcast;
  logic                         out_valid;
  logic                         out_ready;
  logic [LANE_W*LANES-1:0]      out_data;
  logic [$clog2(LANES+1)-1:0]   out_count;

  modport master (
    output in_valid, in_data, in_last, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bcast, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/vector_packer.sv
// Packs 16-bit scalar beats into a LANES-wide vector with zero-pad flush or broadcast close.
// Output valid one edge after the closing beat; in_ready drops only while a closed vector waits.
module vector_packer #(
  parameter int LANE_W = 16,
  parameter int LANES  = 16
) (
  input logic            clk,
  input logic            rst,
  vector_packer_if.slave bus
);
  localparam int IDX_W = $clog2(LANES);
  localparam int CNT_W = $clog2(LANES + 1);

  logic [LANES-1:0][LANE_W-1:0] asm_data_q, asm_data_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         asm_done_q, asm_done_d;
  logic [CNT_W-1:0]             asm_cnt_q, asm_cnt_d;
  logic [LANES*LANE_W-1:0]      out_data_q, out_data_d;
  logic [CNT_W-1:0]             out_count_q, out_count_d;
  logic                         out_valid_q, out_valid_d;
  logic                         accept;
  logic                         xfer;

  // accept and xfer are mutually exclusive because they test opposite values of asm_done_q
  assign accept = bus.in_valid && !asm_done_q;
  assign xfer   = asm_done_q && (!out_valid_q || bus.out_ready);

  always_comb begin
    asm_data_d  = asm_data_q;
    idx_d       = idx_q;
    asm_done_d  = asm_done_q;
    asm_cnt_d   = asm_cnt_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;

    if (xfer) begin
      out_data_d  = asm_data_q;
      out_count_d = asm_cnt_q;
      out_valid_d = 1'b1;
      asm_data_d  = '0;
      idx_d       = '0;
      asm_done_d  = 1'b0;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        if ((IDX_W'(k) == idx_q) || (bus.in_bcast && (IDX_W'(k) >= idx_q))) begin
          asm_data_d[k] = bus.in_data;
        end
      end
      if (bus.in_bcast) begin
        asm_cnt_d  = CNT_W'(LANES);
        asm_done_d = 1'b1;
      end else if (bus.in_last) begin
        asm_cnt_d  = CNT_W'(idx_q) + CNT_W'(1);
        asm_done_d = 1'b1;
      end else if (idx_q == IDX_W'(LANES - 1)) begin
        asm_cnt_d  = CNT_W'(LANES);
        asm_done_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_data_q  <= '0;
      idx_q       <= '0;
      asm_done_q  <= 1'b0;
      asm_cnt_q   <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      asm_data_q  <= asm_data_d;
      idx_q       <= idx_d;
      asm_done_q  <= asm_done_d;
      asm_cnt_q   <= asm_cnt_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = !asm_done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_vector_packer.sv
// Directed stimulus with a scoreboard queue; a negedge monitor pops and compares every vector handed off.
module tb_vector_packer;
  localparam int LW = 16;
  localparam int LN = 16;
  localparam int DW = LW * LN;
  localparam int CW = 5;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
    logic [15:0]   sum;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  vector_packer_if #(.LANE_W(LW), .LANES(LN)) bus ();

  vector_packer #(.LANE_W(LW), .LANES(LN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] lane_sum(input logic [DW-1:0] v);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < LN; k++) s = s + v[k*LW +: LW];
    return s;
  endfunction

  task automatic push(input logic [DW-1:0] d, input int c, input logic [15:0] s);
    exp_t e;
    e.data = d;
    e.cnt  = CW'(c);
    e.sum  = s;
    sb.push_back(e);
  endtask

  task automatic send(input logic [15:0] d, input logic l, input logic b);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_bcast = b;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t = t + 1;
    end
    if (!bus.in_ready) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL send_timeout: in_ready got 0 required 1");
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_bcast = 1'b0;
  endtask

  // Pops on every handshake; while stalled the held vector must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        total = total + 1;
        bad = bad + 1;
        $display("FAIL unexpected_out: got %h required no vector", bus.out_data);
      end else if (bus.out_ready) begin
        mon_e = sb.pop_front();
        chk("out_data", bus.out_data, mon_e.data);
        chk("out_count", DW'(bus.out_count), DW'(mon_e.cnt));
        chk("lane_sum", DW'(lane_sum(bus.out_data)), DW'(mon_e.sum));
      end else begin
        chk("held_data", bus.out_data, sb[0].data);
        chk("held_count", DW'(bus.out_count), DW'(sb[0].cnt));
      end
    end
  end

  initial begin
    logic [DW-1:0] v;
    int prev;
    int t;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_bcast  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_out_count", DW'(bus.out_count), DW'(0));
    chk("rst_in_ready", DW'(bus.in_ready), DW'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // full vector 1..16, sum 0x88
    v = '0;
    for (int k = 0; k < LN; k++) v[k*LW +: LW] = 16'(k + 1);
    push(v, 16, 16'h0088);
    for (int k = 0; k < LN; k++) send(16'(k + 1), 1'b0, 1'b0);
    chk("full_close_in_ready", DW'(bus.in_ready), DW'(0));
    chk("full_close_out_valid", DW'(bus.out_valid), DW'(0));
    @(posedge clk);
    #1;
    chk("full_out_valid", DW'(bus.out_valid), DW'(1));
    chk("full_in_ready_back", DW'(bus.in_ready), DW'(1));
    @(posedge clk);
    #1;
    chk("full_drained", DW'(bus.out_valid), DW'(0));

    // partial flush A,B,C
    v = '0;
    v[15:0]  = 16'h000A;
    v[31:16] = 16'h000B;
    v[47:32] = 16'h000C;
    push(v, 3, 16'h0021);
    send(16'h000A, 1'b0, 1'b0);
    send(16'h000B, 1'b0, 1'b0);
    send(16'h000C, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // broadcast at idx 0, back to back
    v = '0;
    for (int k = 0; k < LN; k++) v[k*LW +: LW] = 16'h0005;
    for (int n = 0; n < 4; n++) push(v, 16, 16'h0050);
    send(16'h0005, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) begin
      prev = acc_cyc;
      send(16'h0005, 1'b0, 1'b1);
      chk("bcast_spacing", DW'(acc_cyc - prev), DW'(2));
    end
    repeat (3) @(posedge clk);
    #1;

    // mixed: two beats then broadcast with last also set
    v = '0;
    v[15:0]  = 16'h1111;
    v[31:16] = 16'h2222;
    for (int k = 2; k < LN; k++) v[k*LW +: LW] = 16'h0007;
    push(v, 16, 16'h3395);
    send(16'h1111, 1'b0, 1'b0);
    send(16'h2222, 1'b0, 1'b0);
    send(16'h0007, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // backpressure: A held, B waits in assembly
    bus.out_ready = 1'b0;
    push(DW'(16'h00A1), 1, 16'h00A1);
    send(16'h00A1, 1'b1, 1'b0);
    push(DW'(16'h00B2), 1, 16'h00B2);
    send(16'h00B2, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_in_ready", DW'(bus.in_ready), DW'(0));
    chk("bp_out_valid", DW'(bus.out_valid), DW'(1));
    chk("bp_hold_a", bus.out_data, DW'(16'h00A1));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_b_valid", DW'(bus.out_valid), DW'(1));
    chk("bp_b_data", bus.out_data, DW'(16'h00B2));
    chk("bp_in_ready_free", DW'(bus.in_ready), DW'(1));
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drained", DW'(bus.out_valid), DW'(0));

    // reset while a vector is on the output and another is half built
    bus.out_ready = 1'b0;
    push(DW'(16'h00C3), 1, 16'h00C3);
    send(16'h00C3, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) send(16'(k + 1), 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    sb.delete();
    chk("mid_rst_out_valid", DW'(bus.out_valid), DW'(0));
    chk("mid_rst_out_data", bus.out_data, '0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", DW'(bus.in_ready), DW'(1));
    push(DW'(16'h00AB), 1, 16'h00AB);
    send(16'h00AB, 1'b1, 1'b0);

    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk);
      t = t + 1;
    end
    #1;
    chk("sb_empty", DW'(sb.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
